// File: rtl/fifo_flagged.sv
// Synchronous FWFT FIFO with occupancy level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
module fifo_flagged #(
    parameter int unsigned DATA_SIZE       = 8,
    parameter int unsigned ADDR_SPACE_EXP  = 4,
    parameter int unsigned ALMOST_FULL_TH  = 12,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    write_to_fifo,
    input  logic                    read_from_fifo,
    input  logic [DATA_SIZE-1:0]    write_data_in,
    output logic [DATA_SIZE-1:0]    read_data_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [ADDR_SPACE_EXP:0] level,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_SPACE_EXP;
    localparam int unsigned PW    = ADDR_SPACE_EXP;
    localparam int unsigned LW    = ADDR_SPACE_EXP + 1;

    localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);
    localparam logic [LW-1:0] AfTh     = LW'(ALMOST_FULL_TH);
    localparam logic [LW-1:0] AeTh     = LW'(ALMOST_EMPTY_TH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          almost_empty_q, almost_empty_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic rd_acc;
    logic wr_acc;

    // A read on a full FIFO frees the slot the concurrent write needs.
    assign rd_acc = read_from_fifo & ~empty_q;
    assign wr_acc = write_to_fifo & (~full_q | rd_acc);

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
            rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
            level_d     = level_q + LW'(wr_acc) - LW'(rd_acc);
            overflow_d  = overflow_q | (write_to_fifo & ~wr_acc);
            underflow_d = underflow_q | (read_from_fifo & ~rd_acc);
        end
        // Flags come from the next level so they line up with the registered level.
        empty_d        = (level_d == '0);
        full_d         = (level_d == DepthLvl);
        almost_empty_d = (level_d <= AeTh);
        almost_full_d  = (level_d >= AfTh);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !clear) begin
            mem_q[wr_ptr_q] <= write_data_in;
        end
    end

    assign read_data_out = mem_q[rd_ptr_q];
    assign empty         = empty_q;
    assign full          = full_q;
    assign almost_empty  = almost_empty_q;
    assign almost_full   = almost_full_q;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule
